// File: rtl/ped_xing_pkg.sv
// rtl/ped_xing_pkg.sv - shared state encoding, default timing and lamp check for the pedestrian crossing controller
package ped_xing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_FAULT = 2'd3
  } xing_state_e;

  localparam int DEF_N_XING       = 2;
  localparam int DEF_WALK_CYCLES  = 10;
  localparam int DEF_CLEAR_CYCLES = 8;
  localparam int DEF_BLINK_HALF   = 1;

  // Traffic lamps are trustworthy only when exactly one of them is lit.
  function automatic logic lamps_onehot(input logic r, input logic y, input logic g);
    return ({r, y, g} == 3'b100) || ({r, y, g} == 3'b010) || ({r, y, g} == 3'b001);
  endfunction

endpackage

// File: rtl/ped_xing_chan.sv
// rtl/ped_xing_chan.sv - one independent pedestrian crossing channel
module ped_xing_chan
  import ped_xing_pkg::*;
#(
  parameter int WALK_CYCLES  = DEF_WALK_CYCLES,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
  input  logic clk,
  input  logic reset,
  input  logic red_i,
  input  logic ylw_i,
  input  logic grn_i,
  input  logic button_i,
  output logic walk_o,
  output logic stop_o,
  output logic rqst_o,
  output logic fault_o
);

  // Timers compare against the value held in the last cycle of a phase.
  localparam logic [7:0] WALK_LAST  = 8'(WALK_CYCLES - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_CYCLES - 1);
  localparam logic [3:0] BLINK_LAST = 4'(BLINK_HALF - 1);

  xing_state_e state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic        phase_q, phase_d;
  logic        rqst_q, rqst_d;
  logic        walk_q, walk_d;
  logic        stop_q, stop_d;
  logic        fault_q, fault_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic        lamps_ok;
  logic        btn_rise;
  logic        entering;

  // Button synchronizer, edge-detect history, FSM state and registered lamp outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      state_q <= ST_IDLE;
      timer_q <= 8'd0;
      bcnt_q  <= 4'd0;
      phase_q <= 1'b0;
      rqst_q  <= 1'b0;
      walk_q  <= 1'b0;
      stop_q  <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      state_q <= state_d;
      timer_q <= timer_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      rqst_q  <= rqst_d;
      walk_q  <= walk_d;
      stop_q  <= stop_d;
      fault_q <= fault_d;
    end
  end

  // Next state, request latch, dwell/blink timing and next lamp values.
  always_comb begin
    state_d  = state_q;
    rqst_d   = rqst_q;
    timer_d  = timer_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    walk_d   = 1'b0;
    stop_d   = 1'b1;
    fault_d  = 1'b0;
    lamps_ok = lamps_onehot(red_i, ylw_i, grn_i);
    btn_rise = sync2_q & ~sync3_q;

    // Presses count only while the walk lamp is not already lit; FAULT holds the request as-is.
    if (btn_rise && (state_q == ST_IDLE || state_q == ST_CLEAR)) begin
      rqst_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!lamps_ok)                  state_d = ST_FAULT;
        else if (grn_i && rqst_q)       state_d = ST_WALK;
      end
      ST_WALK: begin
        if (!lamps_ok)                          state_d = ST_FAULT;
        else if (!grn_i || timer_q >= WALK_LAST) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!lamps_ok)                          state_d = ST_FAULT;
        else if (red_i || timer_q >= CLEAR_LAST) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (lamps_ok && red_i)          state_d = ST_IDLE;
      end
      default: state_d = ST_FAULT;
    endcase

    entering = (state_d != state_q);

    if (state_q == ST_IDLE && state_d == ST_WALK) begin
      rqst_d = 1'b0;
    end

    // Dwell timer restarts on every state entry and sticks at its ceiling.
    if (entering)                 timer_d = 8'd0;
    else if (timer_q != 8'hFF)    timer_d = timer_q + 8'd1;

    // Blink starts lit on entry and toggles every BLINK_HALF cycles while clearing.
    if (entering) begin
      phase_d = 1'b1;
      bcnt_d  = 4'd0;
    end else if (state_q == ST_CLEAR) begin
      if (bcnt_q >= BLINK_LAST) begin
        phase_d = ~phase_q;
        bcnt_d  = 4'd0;
      end else begin
        bcnt_d  = bcnt_q + 4'd1;
      end
    end

    case (state_d)
      ST_IDLE:  stop_d = 1'b1;
      ST_WALK: begin
        walk_d = 1'b1;
        stop_d = 1'b0;
      end
      ST_CLEAR: stop_d = phase_d;
      ST_FAULT: begin
        walk_d  = 1'b1;
        stop_d  = 1'b1;
        fault_d = 1'b1;
      end
      default:  stop_d = 1'b1;
    endcase
  end

  assign walk_o  = walk_q;
  assign stop_o  = stop_q;
  assign rqst_o  = rqst_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/ped_xing_ctrl.sv
// rtl/ped_xing_ctrl.sv - array of independent pedestrian crossing channels
module ped_xing_ctrl
  import ped_xing_pkg::*;
#(
  parameter int N_XING       = DEF_N_XING,
  parameter int WALK_CYCLES  = DEF_WALK_CYCLES,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_XING-1:0] red,
  input  logic [N_XING-1:0] ylw,
  input  logic [N_XING-1:0] grn,
  input  logic [N_XING-1:0] button,
  output logic [N_XING-1:0] walk,
  output logic [N_XING-1:0] stop,
  output logic [N_XING-1:0] rqst,
  output logic [N_XING-1:0] fault
);

  for (genvar g = 0; g < N_XING; g++) begin : g_chan
    ped_xing_chan #(
      .WALK_CYCLES  (WALK_CYCLES),
      .CLEAR_CYCLES (CLEAR_CYCLES),
      .BLINK_HALF   (BLINK_HALF)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .red_i    (red[g]),
      .ylw_i    (ylw[g]),
      .grn_i    (grn[g]),
      .button_i (button[g]),
      .walk_o   (walk[g]),
      .stop_o   (stop[g]),
      .rqst_o   (rqst[g]),
      .fault_o  (fault[g])
    );
  end

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// tb/tb_ped_xing_ctrl.sv - vector/scoreboard bench for ped_xing_ctrl
module tb_ped_xing_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] red, ylw, grn, button;
  logic [1:0] walk, stop, rqst, fault;

  int total;
  int bad;

  typedef struct packed {
    logic [1:0] red;
    logic [1:0] ylw;
    logic [1:0] grn;
    logic [1:0] btn;
    logic [1:0] walk;
    logic [1:0] stop;
    logic [1:0] rqst;
    logic [1:0] fault;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl_a[21];

  ped_xing_ctrl #(
    .N_XING       (2),
    .WALK_CYCLES  (10),
    .CLEAR_CYCLES (6),
    .BLINK_HALF   (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .red    (red),
    .ylw    (ylw),
    .grn    (grn),
    .button (button),
    .walk   (walk),
    .stop   (stop),
    .rqst   (rqst),
    .fault  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [1:0] r, input logic [1:0] y, input logic [1:0] g,
                              input logic [1:0] b, input logic [1:0] w, input logic [1:0] s,
                              input logic [1:0] q, input logic [1:0] f);
    return {r, y, g, b, w, s, q, f};
  endfunction

  task automatic check_front(input string nm);
    vec_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = exp_q.pop_front();
      if ({walk, stop, rqst, fault} !== {e.walk, e.stop, e.rqst, e.fault}) begin
        bad++;
        $display("FAIL %s: got walk=%b stop=%b rqst=%b fault=%b want walk=%b stop=%b rqst=%b fault=%b",
                 nm, walk, stop, rqst, fault, e.walk, e.stop, e.rqst, e.fault);
      end
    end
  endtask

  // Drive one cycle of inputs, expect the outputs registered on the following edge.
  task automatic vec(input vec_t v, input string nm);
    exp_q.push_back(v);
    red    = v.red;
    ylw    = v.ylw;
    grn    = v.grn;
    button = v.btn;
    @(posedge clk);
    #1;
    check_front(nm);
  endtask

  // Check outputs right now, without a clock edge.
  task automatic now_chk(input vec_t v, input string nm);
    exp_q.push_back(v);
    check_front(nm);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    red    = 2'b11;
    ylw    = 2'b00;
    grn    = 2'b00;
    button = 2'b00;

    // ch0 full cycle; ch1 parked on red
    tbl_a[0] = mk(2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl_a[1] = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl_a[2] = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00);
    for (int i = 3; i <= 12; i++)
      tbl_a[i] = mk(2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
    tbl_a[13] = mk(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl_a[14] = mk(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl_a[15] = mk(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    tbl_a[16] = mk(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
    tbl_a[17] = mk(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl_a[18] = mk(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl_a[19] = mk(2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    tbl_a[20] = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);

    #1;
    now_chk(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00), "reset_state");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 21; i++)
      vec(tbl_a[i], $sformatf("ch0_cycle[%0d]", i));

    // ch1 walk cut short by yellow, then red ends clear early; ch0 untouched
    vec(mk(2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00), "ch1_btn0");
    vec(mk(2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00), "ch1_btn1");
    vec(mk(2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00), "ch1_rqst");
    for (int i = 0; i < 4; i++)
      vec(mk(2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00), $sformatf("ch1_walk[%0d]", i));
    vec(mk(2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00), "ch1_clear0");
    vec(mk(2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00), "ch1_clear1");
    vec(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00), "ch1_red_exit");

    // ch0 request survives a lamp fault
    vec(mk(2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00), "flt_btn0");
    vec(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00), "flt_btn1");
    vec(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00), "flt_rqst");
    vec(mk(2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b01, 2'b01), "flt_enter");
    vec(mk(2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 2'b01, 2'b01), "flt_hold_ylw");
    vec(mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00), "flt_exit_red");

    // ch0 walks on the held request; ch1 collects a request that reset must drop
    vec(mk(2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00), "rst_walk1");
    vec(mk(2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00), "rst_walk2");
    vec(mk(2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00), "rst_walk3");
    vec(mk(2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00), "rst_walk4");
    vec(mk(2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00), "rst_walk5");
    #2;
    reset = 1'b1;
    #1;
    now_chk(mk(2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00), "rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      vec(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00), $sformatf("rst_no_walk[%0d]", i));

    // press during WALK ignored, press during CLEAR latched and served next green
    vec(mk(2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00), "rw_btn0");
    vec(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00), "rw_btn1");
    vec(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00), "rw_rqst");
    vec(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00), "rw_walk0");
    vec(mk(2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00), "rw_walk_btn");
    for (int i = 2; i < 10; i++)
      vec(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00), $sformatf("rw_walk[%0d]", i));
    vec(mk(2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00), "rw_clear0");
    vec(mk(2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00), "rw_clear1");
    vec(mk(2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00), "rw_clear2");
    vec(mk(2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00), "rw_clear3");
    vec(mk(2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00), "rw_clear4");
    vec(mk(2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00), "rw_clear5");
    vec(mk(2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00), "rw_idle");
    vec(mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00), "rw_second_walk");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
